// File: rtl/exe_stage.sv
// LA32R execute stage: latches the ID bus, runs the ALU, issues the data-SRAM
// request with byte strobes and alignment checking, and feeds bypass info to ID.

module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  logic op_add, op_sub, op_slt, op_sltu, op_and, op_nor;
  logic op_or, op_xor, op_sll, op_srl, op_sra, op_lui;

  assign op_add  = alu_op[0];
  assign op_sub  = alu_op[1];
  assign op_slt  = alu_op[2];
  assign op_sltu = alu_op[3];
  assign op_and  = alu_op[4];
  assign op_nor  = alu_op[5];
  assign op_or   = alu_op[6];
  assign op_xor  = alu_op[7];
  assign op_sll  = alu_op[8];
  assign op_srl  = alu_op[9];
  assign op_sra  = alu_op[10];
  assign op_lui  = alu_op[11];

  logic        use_sub;
  logic [31:0] adder_b;
  logic [32:0] adder_sum;
  logic [31:0] add_sub_result;
  logic        adder_cout;
  logic [31:0] slt_result;
  logic [31:0] sltu_result;
  logic [31:0] and_result;
  logic [31:0] nor_result;
  logic [31:0] or_result;
  logic [31:0] xor_result;
  logic [31:0] sll_result;
  logic [31:0] srl_result;
  logic [31:0] sra_result;
  logic [31:0] lui_result;

  // Subtract and both compares share one adder computing src1 + ~src2 + 1.
  assign use_sub        = op_sub | op_slt | op_sltu;
  assign adder_b        = use_sub ? ~alu_src2 : alu_src2;
  assign adder_sum      = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, use_sub};
  assign add_sub_result = adder_sum[31:0];
  assign adder_cout     = adder_sum[32];

  assign slt_result  = {31'd0, (alu_src1[31] & ~alu_src2[31])
                              | (~(alu_src1[31] ^ alu_src2[31]) & add_sub_result[31])};
  assign sltu_result = {31'd0, ~adder_cout};
  assign and_result  = alu_src1 & alu_src2;
  assign nor_result  = ~(alu_src1 | alu_src2);
  assign or_result   = alu_src1 | alu_src2;
  assign xor_result  = alu_src1 ^ alu_src2;
  assign sll_result  = alu_src1 << alu_src2[4:0];
  assign srl_result  = alu_src1 >> alu_src2[4:0];
  assign sra_result  = $signed(alu_src1) >>> alu_src2[4:0];
  // ID has already shifted the lu12i immediate into place.
  assign lui_result  = alu_src2;

  assign alu_result = ({32{op_add | op_sub}} & add_sub_result)
                    | ({32{op_slt}}          & slt_result)
                    | ({32{op_sltu}}         & sltu_result)
                    | ({32{op_and}}          & and_result)
                    | ({32{op_nor}}          & nor_result)
                    | ({32{op_or}}           & or_result)
                    | ({32{op_xor}}          & xor_result)
                    | ({32{op_sll}}          & sll_result)
                    | ({32{op_srl}}          & srl_result)
                    | ({32{op_sra}}          & sra_result)
                    | ({32{op_lui}}          & lui_result);

endmodule

module exe_stage #(
  parameter int DS_ES_BUS_W = 151,
  parameter int ES_MS_BUS_W = 76
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   ds_to_es_valid,
  output logic                   es_allowin,
  input  logic [DS_ES_BUS_W-1:0] ds_to_es_bus,
  input  logic                   ms_allowin,
  output logic                   es_to_ms_valid,
  output logic [ES_MS_BUS_W-1:0] es_to_ms_bus,
  output logic                   data_sram_en,
  output logic [3:0]             data_sram_we,
  output logic [31:0]            data_sram_addr,
  output logic [31:0]            data_sram_wdata,
  output logic                   es_fwd_valid,
  output logic [4:0]             es_fwd_dest,
  output logic [31:0]            es_fwd_data,
  output logic                   es_is_load
);

  logic                   es_valid_q, es_valid_d;
  logic [DS_ES_BUS_W-1:0] es_bus_q, es_bus_d;
  logic                   es_ready_go;

  logic [31:0] es_pc;
  logic [11:0] es_alu_op;
  logic [31:0] es_alu_src1;
  logic [31:0] es_alu_src2;
  logic [31:0] es_rkd_value;
  logic [4:0]  es_mem_op;
  logic [4:0]  es_dest;
  logic        es_gr_we;

  assign es_pc        = es_bus_q[150:119];
  assign es_alu_op    = es_bus_q[118:107];
  assign es_alu_src1  = es_bus_q[106:75];
  assign es_alu_src2  = es_bus_q[74:43];
  assign es_rkd_value = es_bus_q[42:11];
  assign es_mem_op    = es_bus_q[10:6];
  assign es_dest      = es_bus_q[5:1];
  assign es_gr_we     = es_bus_q[0];

  logic       is_load;
  logic       is_store;
  logic       is_mem;
  logic [1:0] mem_size;
  logic       size_byte;
  logic       size_half;
  logic       size_word;

  assign is_load   = es_mem_op[4];
  assign is_store  = es_mem_op[3];
  assign is_mem    = is_load | is_store;
  assign mem_size  = es_mem_op[1:0];
  assign size_byte = (mem_size == 2'b00);
  assign size_half = (mem_size == 2'b01);
  assign size_word = mem_size[1];

  assign es_ready_go    = 1'b1;
  // Gated by resetn so ID sees no allowin while the core is held in reset.
  assign es_allowin     = resetn & (~es_valid_q | (es_ready_go & ms_allowin));
  assign es_to_ms_valid = es_valid_q & es_ready_go & ~flush;

  always_comb begin
    es_valid_d = es_valid_q;
    es_bus_d   = es_bus_q;
    if (flush) begin
      es_valid_d = 1'b0;
    end else if (es_allowin) begin
      es_valid_d = ds_to_es_valid;
    end
    if (es_allowin && ds_to_es_valid) begin
      es_bus_d = ds_to_es_bus;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid_q <= 1'b0;
      es_bus_q   <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      es_bus_q   <= es_bus_d;
    end
  end

  logic [31:0] alu_result;

  alu u_alu (
    .alu_op     (es_alu_op),
    .alu_src1   (es_alu_src1),
    .alu_src2   (es_alu_src2),
    .alu_result (alu_result)
  );

  logic        es_ale;
  logic [3:0]  store_strb;
  logic [31:0] store_data;

  assign es_ale = es_valid_q & is_mem
                & ((size_half & alu_result[0]) | (size_word & (alu_result[1:0] != 2'b00)));

  always_comb begin
    store_strb = 4'b1111;
    store_data = es_rkd_value;
    if (size_byte) begin
      store_strb = 4'b0001 << alu_result[1:0];
      store_data = {4{es_rkd_value[7:0]}};
    end else if (size_half) begin
      store_strb = alu_result[1] ? 4'b1100 : 4'b0011;
      store_data = {2{es_rkd_value[15:0]}};
    end
  end

  // The request fires only in the handoff cycle so each memory op is issued once.
  assign data_sram_en    = es_valid_q & is_mem & ~es_ale & ~flush & ms_allowin;
  assign data_sram_we    = {4{data_sram_en & is_store}} & store_strb;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = store_data;

  assign es_fwd_valid = es_valid_q & es_gr_we & (es_dest != 5'd0) & ~es_ale;
  assign es_fwd_dest  = es_dest;
  assign es_fwd_data  = alu_result;
  assign es_is_load   = es_valid_q & is_load;

  assign es_to_ms_bus = {es_pc, alu_result, es_dest, es_gr_we, es_mem_op, es_ale};

endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage: ALU, stores/loads, alignment,
// backpressure, flush and asynchronous reset.

module tb_exe_stage;

  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SUB  = 12'h002;
  localparam logic [11:0] OP_SLT  = 12'h004;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_SLL  = 12'h100;
  localparam logic [11:0] OP_SRA  = 12'h400;
  localparam logic [11:0] OP_LUI  = 12'h800;

  localparam logic [4:0] MEM_NONE = 5'b00000;
  localparam logic [4:0] ST_B     = 5'b01000;
  localparam logic [4:0] ST_H     = 5'b01001;
  localparam logic [4:0] ST_W     = 5'b01010;
  localparam logic [4:0] LD_W     = 5'b10010;

  logic         clk;
  logic         resetn;
  logic         flush;
  logic         ds_to_es_valid;
  logic         es_allowin;
  logic [150:0] ds_to_es_bus;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [75:0]  es_to_ms_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         es_fwd_valid;
  logic [4:0]   es_fwd_dest;
  logic [31:0]  es_fwd_data;
  logic         es_is_load;

  int total;
  int bad;

  exe_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush           (flush),
    .ds_to_es_valid  (ds_to_es_valid),
    .es_allowin      (es_allowin),
    .ds_to_es_bus    (ds_to_es_bus),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .es_fwd_valid    (es_fwd_valid),
    .es_fwd_dest     (es_fwd_dest),
    .es_fwd_data     (es_fwd_data),
    .es_is_load      (es_is_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [150:0] make_bus(input logic [31:0] pc, input logic [11:0] op,
                                            input logic [31:0] s1, input logic [31:0] s2,
                                            input logic [31:0] rkd, input logic [4:0] mop,
                                            input logic [4:0] dest, input logic we);
    return {pc, op, s1, s2, rkd, mop, dest, we};
  endfunction

  // Advance to 1ns after the next rising edge; inputs are driven there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    ds_to_es_valid = 1'b0;
    flush          = 1'b0;
    ms_allowin     = 1'b1;
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; ds_to_es_valid = 1'b0; ms_allowin = 1'b1;
    ds_to_es_bus = '0;
    #12;
    total++; if (es_allowin !== 1'b0) begin bad++; $display("FAIL reset_allowin got=%b exp=0", es_allowin); end
    total++; if (es_to_ms_valid !== 1'b0) begin bad++; $display("FAIL reset_ms_valid got=%b exp=0", es_to_ms_valid); end
    total++; if (data_sram_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", data_sram_en); end
    total++; if (es_to_ms_bus !== 76'd0) begin bad++; $display("FAIL reset_bus got=%h exp=0", es_to_ms_bus); end
    total++; if (es_fwd_valid !== 1'b0) begin bad++; $display("FAIL reset_fwd got=%b exp=0", es_fwd_valid); end
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic test_add();
    ds_to_es_bus   = make_bus(32'h1c000000, OP_ADD, 32'h7FFFFFFF, 32'd1, 32'd0, MEM_NONE, 5'd5, 1'b1);
    ds_to_es_valid = 1'b1;
    ms_allowin     = 1'b1;
    #1;
    total++; if (es_allowin !== 1'b1) begin bad++; $display("FAIL add_allowin got=%b exp=1", es_allowin); end
    step();
    ds_to_es_valid = 1'b0;
    #1;
    total++; if (es_to_ms_valid !== 1'b1) begin bad++; $display("FAIL add_ms_valid got=%b exp=1", es_to_ms_valid); end
    total++; if (es_to_ms_bus[43:12] !== 32'h80000000) begin bad++; $display("FAIL add_result got=%h exp=80000000", es_to_ms_bus[43:12]); end
    total++; if (es_to_ms_bus[75:44] !== 32'h1c000000) begin bad++; $display("FAIL add_pc got=%h exp=1c000000", es_to_ms_bus[75:44]); end
    total++; if (es_fwd_valid !== 1'b1) begin bad++; $display("FAIL add_fwd_valid got=%b exp=1", es_fwd_valid); end
    total++; if (es_fwd_dest !== 5'd5) begin bad++; $display("FAIL add_fwd_dest got=%0d exp=5", es_fwd_dest); end
    total++; if (data_sram_en !== 1'b0) begin bad++; $display("FAIL add_en got=%b exp=0", data_sram_en); end
    drain();
  endtask

  task automatic test_alu_ops();
    logic [11:0] ops [6]  = '{OP_SUB, OP_SLT, OP_SLTU, OP_SLL, OP_SRA, OP_LUI};
    logic [31:0] a   [6]  = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'h80000000, 32'h0};
    logic [31:0] b   [6]  = '{32'd7, 32'd1, 32'd1, 32'd4, 32'd4, 32'hABCDE000};
    logic [31:0] exp [6]  = '{32'hFFFFFFFE, 32'd1, 32'd0, 32'd16, 32'hF8000000, 32'hABCDE000};
    for (int i = 0; i < 6; i++) begin
      ds_to_es_bus   = make_bus(32'h100 + 32'(i), ops[i], a[i], b[i], 32'd0, MEM_NONE, 5'd3, 1'b1);
      ds_to_es_valid = 1'b1;
      step();
      ds_to_es_valid = 1'b0;
      #1;
      total++; if (es_fwd_data !== exp[i]) begin bad++; $display("FAIL alu_op%0d got=%h exp=%h", i, es_fwd_data, exp[i]); end
    end
    drain();
  endtask

  task automatic test_store_byte();
    ds_to_es_bus   = make_bus(32'h200, OP_ADD, 32'h1000, 32'd3, 32'h000000A5, ST_B, 5'd0, 1'b0);
    ds_to_es_valid = 1'b1;
    step();
    ds_to_es_valid = 1'b0;
    #1;
    total++; if (data_sram_en !== 1'b1) begin bad++; $display("FAIL stb_en got=%b exp=1", data_sram_en); end
    total++; if (data_sram_we !== 4'b1000) begin bad++; $display("FAIL stb_we got=%b exp=1000", data_sram_we); end
    total++; if (data_sram_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL stb_wdata got=%h exp=a5a5a5a5", data_sram_wdata); end
    total++; if (data_sram_addr !== 32'h1003) begin bad++; $display("FAIL stb_addr got=%h exp=1003", data_sram_addr); end
    total++; if (es_fwd_valid !== 1'b0) begin bad++; $display("FAIL stb_fwd got=%b exp=0", es_fwd_valid); end
    step();
    total++; if (data_sram_en !== 1'b0) begin bad++; $display("FAIL stb_single_pulse got=%b exp=0", data_sram_en); end
    drain();
  endtask

  task automatic test_half_and_misaligned();
    ds_to_es_bus   = make_bus(32'h300, OP_ADD, 32'h2000, 32'd2, 32'h1234BEEF, ST_H, 5'd0, 1'b0);
    ds_to_es_valid = 1'b1;
    step();
    ds_to_es_bus   = make_bus(32'h304, OP_ADD, 32'h2000, 32'd2, 32'd0, LD_W, 5'd4, 1'b1);
    #1;
    total++; if (data_sram_we !== 4'b1100) begin bad++; $display("FAIL sth_we got=%b exp=1100", data_sram_we); end
    total++; if (data_sram_wdata !== 32'hBEEFBEEF) begin bad++; $display("FAIL sth_wdata got=%h exp=beefbeef", data_sram_wdata); end
    total++; if (es_to_ms_bus[0] !== 1'b0) begin bad++; $display("FAIL sth_ale got=%b exp=0", es_to_ms_bus[0]); end
    step();
    ds_to_es_valid = 1'b0;
    #1;
    total++; if (es_to_ms_bus[0] !== 1'b1) begin bad++; $display("FAIL ldw_ale got=%b exp=1", es_to_ms_bus[0]); end
    total++; if (data_sram_en !== 1'b0) begin bad++; $display("FAIL ldw_ale_en got=%b exp=0", data_sram_en); end
    total++; if (es_to_ms_valid !== 1'b1) begin bad++; $display("FAIL ldw_ale_valid got=%b exp=1", es_to_ms_valid); end
    total++; if (es_fwd_valid !== 1'b0) begin bad++; $display("FAIL ldw_ale_fwd got=%b exp=0", es_fwd_valid); end
    total++; if (es_to_ms_bus[6] !== 1'b1) begin bad++; $display("FAIL ldw_ale_grwe got=%b exp=1", es_to_ms_bus[6]); end
    drain();
  endtask

  task automatic test_stall();
    ds_to_es_bus   = make_bus(32'h400, OP_ADD, 32'h3000, 32'd0, 32'd0, LD_W, 5'd6, 1'b1);
    ds_to_es_valid = 1'b1;
    ms_allowin     = 1'b0;
    step();
    ds_to_es_bus   = make_bus(32'h404, OP_ADD, 32'd10, 32'd20, 32'd0, MEM_NONE, 5'd7, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (es_allowin !== 1'b0) begin bad++; $display("FAIL stall_allowin c%0d got=%b exp=0", c, es_allowin); end
      total++; if (data_sram_en !== 1'b0) begin bad++; $display("FAIL stall_en c%0d got=%b exp=0", c, data_sram_en); end
      total++; if (es_is_load !== 1'b1) begin bad++; $display("FAIL stall_is_load c%0d got=%b exp=1", c, es_is_load); end
      total++; if (es_to_ms_bus[75:44] !== 32'h400) begin bad++; $display("FAIL stall_pc c%0d got=%h exp=400", c, es_to_ms_bus[75:44]); end
      step();
    end
    ms_allowin = 1'b1;
    #1;
    total++; if (data_sram_en !== 1'b1) begin bad++; $display("FAIL stall_release_en got=%b exp=1", data_sram_en); end
    total++; if (es_allowin !== 1'b1) begin bad++; $display("FAIL stall_release_allowin got=%b exp=1", es_allowin); end
    total++; if (data_sram_addr !== 32'h3000) begin bad++; $display("FAIL stall_addr got=%h exp=3000", data_sram_addr); end
    total++; if (data_sram_we !== 4'b0000) begin bad++; $display("FAIL stall_we got=%b exp=0000", data_sram_we); end
    step();
    ds_to_es_valid = 1'b0;
    #1;
    total++; if (es_fwd_dest !== 5'd7) begin bad++; $display("FAIL b2b_dest got=%0d exp=7", es_fwd_dest); end
    total++; if (es_fwd_data !== 32'd30) begin bad++; $display("FAIL b2b_data got=%0d exp=30", es_fwd_data); end
    total++; if (es_is_load !== 1'b0) begin bad++; $display("FAIL b2b_is_load got=%b exp=0", es_is_load); end
    total++; if (data_sram_en !== 1'b0) begin bad++; $display("FAIL b2b_en got=%b exp=0", data_sram_en); end
    drain();
  endtask

  task automatic test_flush();
    ds_to_es_bus   = make_bus(32'h500, OP_ADD, 32'h4000, 32'd0, 32'hDEADBEEF, ST_W, 5'd0, 1'b0);
    ds_to_es_valid = 1'b1;
    step();
    ds_to_es_bus   = make_bus(32'h504, OP_ADD, 32'd1, 32'd1, 32'd0, MEM_NONE, 5'd9, 1'b1);
    flush          = 1'b1;
    #1;
    total++; if (data_sram_en !== 1'b0) begin bad++; $display("FAIL flush_en got=%b exp=0", data_sram_en); end
    total++; if (data_sram_we !== 4'b0000) begin bad++; $display("FAIL flush_we got=%b exp=0000", data_sram_we); end
    total++; if (es_to_ms_valid !== 1'b0) begin bad++; $display("FAIL flush_ms_valid got=%b exp=0", es_to_ms_valid); end
    step();
    flush = 1'b0; ds_to_es_valid = 1'b0;
    #1;
    total++; if (es_to_ms_valid !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b exp=0", es_to_ms_valid); end
    total++; if (es_fwd_valid !== 1'b0) begin bad++; $display("FAIL flush_drop_fwd got=%b exp=0", es_fwd_valid); end
    // Flush while MEM is stalling a load.
    ds_to_es_bus   = make_bus(32'h508, OP_ADD, 32'h5000, 32'd0, 32'd0, LD_W, 5'd2, 1'b1);
    ds_to_es_valid = 1'b1;
    ms_allowin     = 1'b0;
    step();
    ds_to_es_valid = 1'b0;
    flush          = 1'b1;
    #1;
    total++; if (es_to_ms_valid !== 1'b0) begin bad++; $display("FAIL flush_stall_valid got=%b exp=0", es_to_ms_valid); end
    step();
    flush = 1'b0;
    #1;
    total++; if (es_allowin !== 1'b1) begin bad++; $display("FAIL flush_stall_allowin got=%b exp=1", es_allowin); end
    total++; if (es_is_load !== 1'b0) begin bad++; $display("FAIL flush_stall_is_load got=%b exp=0", es_is_load); end
    drain();
  endtask

  task automatic test_async_reset();
    ds_to_es_bus   = make_bus(32'h600, OP_ADD, 32'h6000, 32'd0, 32'h11, ST_B, 5'd5, 1'b1);
    ds_to_es_valid = 1'b1;
    ms_allowin     = 1'b1;
    step();
    ds_to_es_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    total++; if (es_to_ms_valid !== 1'b0) begin bad++; $display("FAIL arst_ms_valid got=%b exp=0", es_to_ms_valid); end
    total++; if (data_sram_en !== 1'b0) begin bad++; $display("FAIL arst_en got=%b exp=0", data_sram_en); end
    total++; if (es_fwd_valid !== 1'b0) begin bad++; $display("FAIL arst_fwd got=%b exp=0", es_fwd_valid); end
    total++; if (es_allowin !== 1'b0) begin bad++; $display("FAIL arst_allowin got=%b exp=0", es_allowin); end
    @(negedge clk);
    resetn = 1'b1;
    step();
    ds_to_es_bus   = make_bus(32'h604, OP_ADD, 32'h7000, 32'd1, 32'h5A, ST_B, 5'd0, 1'b0);
    ds_to_es_valid = 1'b1;
    step();
    ds_to_es_valid = 1'b0;
    #1;
    total++; if (data_sram_en !== 1'b1) begin bad++; $display("FAIL arst_after_en got=%b exp=1", data_sram_en); end
    total++; if (data_sram_we !== 4'b0010) begin bad++; $display("FAIL arst_after_we got=%b exp=0010", data_sram_we); end
    total++; if (data_sram_wdata !== 32'h5A5A5A5A) begin bad++; $display("FAIL arst_after_wdata got=%h exp=5a5a5a5a", data_sram_wdata); end
    drain();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add();
    test_alu_ops();
    test_store_byte();
    test_half_and_misaligned();
    test_stall();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
